// File: rtl/audio_pkg.sv
// Shared constants and frame-state encoding for the codec audio path.
package audio_pkg;
    localparam int AUDIO_DATA_WIDTH = 32;
    localparam int AUDIO_BITS       = 24;
    localparam int AUDIO_FIFO_DEPTH = 16;
    localparam int AUDIO_FIFO_AW    = 4;

    typedef enum logic [1:0] {
        ST_WAIT_FRAME = 2'd0,
        ST_LEFT       = 2'd1,
        ST_RIGHT      = 2'd2
    } frame_state_t;
endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous sample-pair FIFO; fullness comes from the level counter, not pointer equality.
module audio_sample_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/audio_dac_serializer.sv
// I2S transmit serializer with codec-mastered BCLK/LRCK and a sample-pair FIFO.
// Optional DAC_UNDERRUN_COUNT_EN adds a saturating underrun_count output.
module audio_dac_serializer #(
    parameter int DATA_WIDTH = audio_pkg::AUDIO_DATA_WIDTH,
    parameter int AUDIO_BITS = audio_pkg::AUDIO_BITS,
    parameter int FIFO_DEPTH = audio_pkg::AUDIO_FIFO_DEPTH,
    parameter int FIFO_AW    = audio_pkg::AUDIO_FIFO_AW
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  clear_audio_out_memory,
    input  logic [DATA_WIDTH-1:0] left_channel_audio_out,
    input  logic [DATA_WIDTH-1:0] right_channel_audio_out,
    input  logic                  write_audio_out,
    output logic                  audio_out_allowed,
    output logic [FIFO_AW:0]      fifo_level,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT
`ifdef DAC_UNDERRUN_COUNT_EN
    ,
    output logic [15:0]           underrun_count
`endif
);
    import audio_pkg::*;

    localparam int CW = $clog2(AUDIO_BITS + 1);

    logic [2:0]              bclk_sync, lrck_sync;
    logic                    bclk_fall, lrck_fall, lrck_rise;
    logic [2*DATA_WIDTH-1:0] fifo_rdata;
    logic                    fifo_full, fifo_empty;
    frame_state_t            state;
    logic [AUDIO_BITS-1:0]   shifter, hold;
    logic [CW-1:0]           bits_left;
    logic                    unused_low_bits;

    // Sub-word LSBs are never transmitted.
    assign unused_low_bits = ^{fifo_rdata[DATA_WIDTH +: DATA_WIDTH-AUDIO_BITS],
                               fifo_rdata[0 +: DATA_WIDTH-AUDIO_BITS]};

    // Sync flops reset low so a pin already low at release never looks like a falling edge.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
        end else begin
            bclk_sync <= {bclk_sync[1:0], AUD_BCLK};
            lrck_sync <= {lrck_sync[1:0], AUD_DACLRCK};
        end
    end

    assign bclk_fall = bclk_sync[2] & ~bclk_sync[1];
    assign lrck_fall = lrck_sync[2] & ~lrck_sync[1];
    assign lrck_rise = ~lrck_sync[2] & lrck_sync[1];

    audio_sample_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .clear (clear_audio_out_memory),
        .push  (write_audio_out),
        .pop   (lrck_fall),
        .wdata ({left_channel_audio_out, right_channel_audio_out}),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign audio_out_allowed = !fifo_full;

    // LRCK edges take priority over a coincident BCLK fall: that fall belongs to the I2S delay slot.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_WAIT_FRAME;
            shifter    <= '0;
            hold       <= '0;
            bits_left  <= '0;
            AUD_DACDAT <= 1'b0;
        end else if (clear_audio_out_memory) begin
            state      <= ST_WAIT_FRAME;
            shifter    <= '0;
            hold       <= '0;
            bits_left  <= '0;
            AUD_DACDAT <= 1'b0;
        end else if (lrck_fall) begin
            state      <= ST_LEFT;
            bits_left  <= CW'(AUDIO_BITS);
            AUD_DACDAT <= 1'b0;
            if (!fifo_empty) begin
                shifter <= fifo_rdata[2*DATA_WIDTH-1 -: AUDIO_BITS];
                hold    <= fifo_rdata[DATA_WIDTH-1 -: AUDIO_BITS];
            end else begin
                shifter <= '0;
                hold    <= '0;
            end
        end else if (lrck_rise && state != ST_WAIT_FRAME) begin
            state      <= ST_RIGHT;
            shifter    <= hold;
            bits_left  <= CW'(AUDIO_BITS);
            AUD_DACDAT <= 1'b0;
        end else if (bclk_fall && state != ST_WAIT_FRAME) begin
            if (bits_left != '0) begin
                AUD_DACDAT <= shifter[AUDIO_BITS-1];
                shifter    <= {shifter[AUDIO_BITS-2:0], 1'b0};
                bits_left  <= bits_left - 1'b1;
            end else begin
                AUD_DACDAT <= 1'b0;
            end
        end
    end

`ifdef DAC_UNDERRUN_COUNT_EN
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            underrun_count <= '0;
        else if (clear_audio_out_memory)
            underrun_count <= '0;
        else if (lrck_fall && fifo_empty && underrun_count != 16'hFFFF)
            underrun_count <= underrun_count + 16'd1;
    end
`endif
endmodule
